// File: rtl/result_writer_pkg.sv
// result_writer shared types: request encoding, FSM states,
// and the cache-line address width.
package result_writer_pkg;

  localparam int LINE_W = 58;

  typedef enum logic {
    WRLINE  = 1'b0,
    WRFENCE = 1'b1
  } wr_type_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    FENCE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/result_writer_mc_fifo.sv
// rw_chan_fifo: single-clock FIFO, one per result channel.
// Head is visible combinationally on rdata; DEPTH is a power of 2.
module rw_chan_fifo #(
  parameter int DATA_W = 512,
  parameter int DEPTH  = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       usedw
);

  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wp_q, wp_d;
  logic [AW:0]       rp_q, rp_d;

  // pointer advance on push/pop; both may happen together
  always_comb begin
    wp_d = wp_q;
    rp_d = rp_q;
    if (push) wp_d = wp_q + PTR_ONE;
    if (pop)  rp_d = rp_q + PTR_ONE;
  end

  // pointer registers; reset empties the FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

  // storage array, contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q[AW-1:0]] <= wdata;
  end

  assign rdata = mem_q[rp_q[AW-1:0]];
  assign usedw = wp_q - rp_q;
  assign full  = (usedw == (AW+1)'(DEPTH));
  assign empty = (wp_q == rp_q);

endmodule

// File: rtl/result_writer_mc.sv
// result_writer_mc: per-channel FIFOs, round-robin WrLine issue,
// WrFence after drain. Optional RESULT_WRITER_STATS_EN adds stat_lines.
module result_writer_mc
  import result_writer_pkg::*;
#(
  parameter int DATA_W       = 512,
  parameter int NUM_CH       = 2,
  parameter int FIFO_DEPTH   = 64,
  parameter int REGION_LINES = 1024,
  parameter int MDATA_W      = 16
) (
  input  logic                     clk,
  input  logic                     resetb,
  input  logic [NUM_CH-1:0]        ch_valid,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [NUM_CH-1:0]        ch_ready,
  input  logic [LINE_W-1:0]        base_line,
  input  logic                     start,
  input  logic                     fence_req,
  input  logic                     dsm_busy,
  input  logic                     wr_almostfull,
  output logic                     wr_valid,
  output logic                     wr_type,
  output logic [LINE_W-1:0]        wr_line,
  output logic [MDATA_W-1:0]       wr_mdata,
  output logic [DATA_W-1:0]        wr_data,
  output logic                     fence_done,
  output logic [NUM_CH-1:0]        wrapped,
  output logic [31:0]              stat_lines
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int OFF_W = $clog2(REGION_LINES);
  localparam int UW    = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_CH-1:0] full, empty, push, pop;
  logic [UW-1:0]     usedw [NUM_CH];
  logic [DATA_W-1:0] rdata [NUM_CH];

  state_t            state_q, state_d;
  logic [CH_W-1:0]   prio_q, prio_d;
  logic [CH_W-1:0]   gnt_idx, cand;
  logic              gnt_any;
  logic [OFF_W-1:0]  off_q [NUM_CH];
  logic [OFF_W-1:0]  off_d [NUM_CH];
  logic [NUM_CH-1:0] wrap_q, wrap_d;
  logic              fpend_q, fpend_d;
  logic              permit, all_empty;

  logic              wr_valid_q, wr_valid_d;
  wr_type_e          wr_type_q, wr_type_d;
  logic [LINE_W-1:0] wr_line_q, wr_line_d;
  logic [MDATA_W-1:0] wr_mdata_q, wr_mdata_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              fdone_q, fdone_d;

  assign push     = ch_valid & ~full;
  assign ch_ready = ~full;
  assign permit   = !wr_almostfull && !dsm_busy;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    rw_chan_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (resetb),
      .push  (push[c]),
      .wdata (ch_data[c*DATA_W +: DATA_W]),
      .pop   (pop[c]),
      .rdata (rdata[c]),
      .full  (full[c]),
      .empty (empty[c]),
      .usedw (usedw[c])
    );
  end

  // round-robin pick: first non-empty channel at or after prio_q
  always_comb begin
    gnt_any   = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    all_empty = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = CH_W'((int'(prio_q) + i) % NUM_CH);
      if (!gnt_any && !empty[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
      if (usedw[i] != '0) all_empty = 1'b0;
    end
  end

  // FSM next state, request build, offsets and fence bookkeeping
  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    off_d      = off_q;
    wrap_d     = wrap_q;
    fpend_d    = fpend_q | fence_req;
    pop        = '0;
    wr_valid_d = 1'b0;
    wr_type_d  = wr_type_q;
    wr_line_d  = wr_line_q;
    wr_mdata_d = wr_mdata_q;
    wr_data_d  = wr_data_q;
    fdone_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_any && permit) begin
          pop[gnt_idx] = 1'b1;
          prio_d       = CH_W'((int'(gnt_idx) + 1) % NUM_CH);
          wr_valid_d   = 1'b1;
          wr_type_d    = WRLINE;
          wr_line_d    = base_line
                       + (LINE_W'(gnt_idx) << OFF_W)
                       + LINE_W'(off_q[gnt_idx]);
          wr_mdata_d   = MDATA_W'({3'(gnt_idx), off_q[gnt_idx]});
          wr_data_d    = rdata[gnt_idx];
          if (off_q[gnt_idx] == OFF_W'(REGION_LINES - 1)) begin
            off_d[gnt_idx]  = '0;
            wrap_d[gnt_idx] = 1'b1;
          end else begin
            off_d[gnt_idx] = off_q[gnt_idx] + OFF_W'(1);
          end
          state_d = ISSUE;
        end else if (fpend_q && all_empty && permit) begin
          wr_valid_d = 1'b1;
          wr_type_d  = WRFENCE;
          wr_line_d  = base_line;
          wr_mdata_d = '0;
          state_d    = FENCE;
        end
      end
      ISSUE: state_d = IDLE;
      FENCE: begin
        fdone_d = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        fpend_d = 1'b0;
        state_d = IDLE;
      end
    endcase
    if (start) begin
      off_d   = '{default: '0};
      wrap_d  = '0;
      fpend_d = 1'b0;
    end
  end

  // state, arbitration pointer, offsets and registered request
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q    <= IDLE;
      prio_q     <= '0;
      off_q      <= '{default: '0};
      wrap_q     <= '0;
      fpend_q    <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_type_q  <= WRLINE;
      wr_line_q  <= '0;
      wr_mdata_q <= '0;
      wr_data_q  <= '0;
      fdone_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      off_q      <= off_d;
      wrap_q     <= wrap_d;
      fpend_q    <= fpend_d;
      wr_valid_q <= wr_valid_d;
      wr_type_q  <= wr_type_d;
      wr_line_q  <= wr_line_d;
      wr_mdata_q <= wr_mdata_d;
      wr_data_q  <= wr_data_d;
      fdone_q    <= fdone_d;
    end
  end

  assign wr_valid   = wr_valid_q;
  assign wr_type    = wr_type_q;
  assign wr_line    = wr_line_q;
  assign wr_mdata   = wr_mdata_q;
  assign wr_data    = wr_data_q;
  assign fence_done = fdone_q;
  assign wrapped    = wrap_q;

`ifdef RESULT_WRITER_STATS_EN
  logic [31:0] stat_q, stat_d;

  // saturating count of WrLine requests presented
  always_comb begin
    stat_d = stat_q;
    if (start)
      stat_d = '0;
    else if (wr_valid_q && wr_type_q == WRLINE && stat_q != '1)
      stat_d = stat_q + 32'd1;
  end

  // line counter register
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) stat_q <= '0;
    else         stat_q <= stat_d;
  end

  assign stat_lines = stat_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_chk
    a_no_underflow : assert property (
      @(posedge clk) disable iff (!resetb) !(pop[c] && empty[c]));
    a_no_overflow : assert property (
      @(posedge clk) disable iff (!resetb) !(push[c] && full[c]));
  end

  a_grant_permit : assert property (
    @(posedge clk) disable iff (!resetb)
    (state_q == IDLE && state_d != IDLE) |-> permit);
`else
  assign stat_lines = '0;
`endif

endmodule
